wave_sel_sched: RTL and testbench
=================================

Name: wave_sel_sched

Overview:
Controller that drives the 2-bit waveform select of the sine/square/triangle/saw BRAM generator. Selection is manual (board switches) or automatic (cycles 0→1→2→3→0 after a programmable number of periods). Every select change is deferred to a waveform period boundary, so the pmod output switches glitch-free. It sits between the board switches and push button and the output mux select.

Parameters:
DWELL_W, 16, width of dwell count and period counter
DB_CYCLES, 1000000, consecutive synchronized-stable cycles required to accept a btn_next level change
TIMEOUT_CYCLES, 4096, stall limit used only with FORCE_SWITCH_TIMEOUT_EN

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
auto_en  input  1  0 = manual select, 1 = auto cycle (asynchronous switch)
man_sel  input  2  manual waveform code: 00 sin, 01 sq, 10 tri, 11 saw (asynchronous switches)
btn_next  input  1  raw push button; in auto mode, skip to next waveform
period_wrap  input  1  one-cycle pulse when the generator address counter wraps to 0
dwell  input  DWELL_W  periods per waveform in auto mode; 0 treated as 1
sel  output  2  registered select to the output mux
pending  output  1  a change is requested but not yet committed
switch_pulse  output  1  one-cycle pulse on the cycle after sel changes
period_cnt  output  DWELL_W  periods elapsed on current waveform in auto mode

Behaviour:
- Reset: sel=00, pending=0, switch_pulse=0, period_cnt=0, FSM=RUN, synchronizers and debouncer cleared, debounced button state=released. Reset mid-PEND discards the pending request.
- auto_en, man_sel and btn_next each pass a 2-FF synchronizer. Decisions use only synchronized values.
- Debounce: the synchronized btn_next must hold a new level for DB_CYCLES consecutive cycles before it is accepted. An accepted 0→1 transition produces one internal press pulse. A release must also be accepted before the next press can register.
- FSM states RUN and PEND. target is the waveform code that sel should move to.
- Manual mode: target=sync man_sel.
  - RUN→PEND on the edge after target≠sel. pending=1.
  - In PEND, if target returns to equal sel: PEND→RUN, no commit, no switch_pulse.
  - In PEND with period_wrap=1: sel←target at that edge, PEND→RUN, pending←0, switch_pulse=1 on the next cycle only.
  - If target changes again while in PEND, the latest target is committed.
  - btn_next is ignored in manual mode.
- Auto mode:
  - In RUN, each period_wrap increments period_cnt.
  - If period_wrap arrives with period_cnt+1 ≥ max(dwell,1): sel←sel+1 mod 4 (11→00), period_cnt←0, switch_pulse next cycle. The commit happens at the wrap edge itself, so pending stays 0.
  - If dwell is lowered below the current period_cnt, the advance happens at the next wrap (≥ compare).
  - An accepted press enters PEND with target=sel+1. The next period_wrap commits it and clears period_cnt.
  - A press and dwell expiry at the same wrap give a single advance of +1, never +2.
  - Further presses while in PEND are ignored.
- Mode change (sync auto_en toggles):
  - period_cnt←0 and FSM→RUN. Any pending auto request is dropped.
  - In manual, man_sel is then evaluated normally.
  - Auto starts from the current sel.
- period_wrap in RUN with no request: no effect beyond the period_cnt update.
- All outputs are registered. There is no combinational path from inputs to outputs.

Optional Feature:
FORCE_SWITCH_TIMEOUT_EN:
- Defined: a stall counter runs while in PEND and clears on leaving PEND. If it reaches TIMEOUT_CYCLES with no period_wrap, sel←target, PEND→RUN and switch_pulse is issued, exactly as for a normal commit. This recovers if the generator clock is stopped.
- Undefined: no counter. PEND waits indefinitely for period_wrap.

Test Plan:
- Reset/manual commit: rst 1 cycle, then man_sel=10 → pending=1 within 3 cycles, sel stays 00; period_wrap pulse → sel=10 at that edge, switch_pulse=1 the next cycle, pending=0.
- Manual cancel: sel=00, man_sel 00→01, then back to 00 before any period_wrap → pending rises then falls, sel=00, switch_pulse never asserted.
- Auto dwell: auto_en=1, dwell=3, five wraps spaced 10 cycles apart → sel 00→01 on wrap 3, period_cnt 1,2,0,1,2; with dwell=0, every wrap advances 00→01→10→11→00.
- Debounce and button: DB_CYCLES=4, auto, dwell=100. A 2-cycle btn glitch → no pending. A 6-cycle press → pending=1; next wrap → sel+1, period_cnt=0. A press coinciding with the dwell-expiry wrap → exactly +1.
- Mode switch and reset mid-PEND: in auto PEND, auto_en→0 with man_sel=sel → pending=0, period_cnt=0. In manual PEND, rst → sel=00, pending=0 on the next cycle.
- FORCE_SWITCH_TIMEOUT_EN, TIMEOUT_CYCLES=8: man_sel=11, no wraps → sel=11 eight cycles after entering PEND; macro undefined → sel unchanged after 100 cycles.

Source files
------------

// File: rtl/wave_sel_sched.sv
`default_nettype none
// ============================================================================
//  Module   : wave_sel_sched
//  Purpose  : Waveform select scheduler for the sine/square/triangle/saw
//             BRAM generator. Manual or automatic (dwell-based) selection,
//             with every select change deferred to a period boundary.
//  Options  : FORCE_SWITCH_TIMEOUT_EN - commit a pending change after
//             TIMEOUT_CYCLES without a period_wrap.
//  Revision : 1.0 - initial release
// ============================================================================
module wave_sel_sched #(
   parameter int DWELL_W        = 16,
   parameter int DB_CYCLES      = 1000000,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               auto_en,
   input  logic [1:0]         man_sel,
   input  logic               btn_next,
   input  logic               period_wrap,
   input  logic [DWELL_W-1:0] dwell,
   output logic [1:0]         sel,
   output logic               pending,
   output logic               switch_pulse,
   output logic [DWELL_W-1:0] period_cnt
);

   localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

   typedef enum logic [0:0] {
      RUN  = 1'b0,
      PEND = 1'b1
   } state_t;

   state_t             state;
   logic               auto_meta, auto_sync, auto_prev;
   logic [1:0]         man_meta, man_sync;
   logic               btn_meta, btn_sync;
   logic               btn_state;
   logic [DB_W-1:0]    db_cnt;
   logic               press;
   logic               mode_chg;
   logic               dwell_hit;
   logic               stall_done;
   logic [DWELL_W:0]   cnt_next;
   logic [DWELL_W:0]   dwell_eff;
   logic [1:0]         next_code;

   // Two-stage synchronizers for the asynchronous switches and button
   always_ff @(posedge clk) begin
      if (rst) begin
         auto_meta <= 1'b0;
         auto_sync <= 1'b0;
         man_meta  <= 2'b00;
         man_sync  <= 2'b00;
         btn_meta  <= 1'b0;
         btn_sync  <= 1'b0;
      end else begin
         auto_meta <= auto_en;
         auto_sync <= auto_meta;
         man_meta  <= man_sel;
         man_sync  <= man_meta;
         btn_meta  <= btn_next;
         btn_sync  <= btn_meta;
      end
   end

   // Press is the cycle an accepted rising level change lands
   always_comb begin
      press = 1'b0;
      if ((btn_sync != btn_state) && (db_cnt == DB_LAST) && btn_sync) begin
         press = 1'b1;
      end
   end

   // Debouncer: a new level must persist DB_CYCLES consecutive cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         btn_state <= 1'b0;
         db_cnt    <= '0;
      end else if (btn_sync == btn_state) begin
         db_cnt    <= '0;
      end else if (db_cnt == DB_LAST) begin
         btn_state <= btn_sync;
         db_cnt    <= '0;
      end else begin
         db_cnt    <= db_cnt + DB_W'(1);
      end
   end

   // Dwell comparison uses one extra bit so cnt+1 never wraps; dwell=0 acts as 1
   always_comb begin
      cnt_next  = {1'b0, period_cnt} + (DWELL_W+1)'(1);
      dwell_eff = (dwell == '0) ? (DWELL_W+1)'(1) : {1'b0, dwell};
      dwell_hit = (cnt_next >= dwell_eff);
      mode_chg  = (auto_sync != auto_prev);
      next_code = sel + 2'd1;
   end

`ifdef FORCE_SWITCH_TIMEOUT_EN
   localparam int ST_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [ST_W-1:0] ST_LAST = ST_W'(TIMEOUT_CYCLES - 1);

   logic [ST_W-1:0] stall_cnt;

   assign stall_done = (state == PEND) && (stall_cnt == ST_LAST);

   // Stall counter: counts cycles spent waiting in PEND, zero elsewhere
   always_ff @(posedge clk) begin
      if (rst || (state != PEND)) begin
         stall_cnt <= '0;
      end else if (!stall_done) begin
         stall_cnt <= stall_cnt + ST_W'(1);
      end
   end
`else
   assign stall_done = 1'b0;
`endif

   // Scheduler FSM: request/commit handling with all outputs registered
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= RUN;
         sel          <= 2'b00;
         pending      <= 1'b0;
         switch_pulse <= 1'b0;
         period_cnt   <= '0;
         auto_prev    <= 1'b0;
      end else begin
         switch_pulse <= 1'b0;
         auto_prev    <= auto_sync;
         if (mode_chg) begin
            // Mode switch drops any request and restarts the dwell count
            state      <= RUN;
            pending    <= 1'b0;
            period_cnt <= '0;
         end else if (!auto_sync) begin
            period_cnt <= '0;
            case (state)
               RUN: begin
                  if (man_sync != sel) begin
                     state   <= PEND;
                     pending <= 1'b1;
                  end
               end
               PEND: begin
                  if (man_sync == sel) begin
                     state   <= RUN;
                     pending <= 1'b0;
                  end else if (period_wrap || stall_done) begin
                     sel          <= man_sync;
                     state        <= RUN;
                     pending      <= 1'b0;
                     switch_pulse <= 1'b1;
                  end
               end
               default: begin
                  state   <= RUN;
                  pending <= 1'b0;
               end
            endcase
         end else begin
            case (state)
               RUN: begin
                  if (period_wrap) begin
                     // A press landing on a wrap folds into this advance
                     if (press || dwell_hit) begin
                        sel          <= next_code;
                        period_cnt   <= '0;
                        switch_pulse <= 1'b1;
                     end else begin
                        period_cnt   <= cnt_next[DWELL_W-1:0];
                     end
                  end else if (press) begin
                     state   <= PEND;
                     pending <= 1'b1;
                  end
               end
               PEND: begin
                  // sel is frozen in PEND, so sel+1 is the requested target
                  if (period_wrap || stall_done) begin
                     sel          <= next_code;
                     period_cnt   <= '0;
                     state        <= RUN;
                     pending      <= 1'b0;
                     switch_pulse <= 1'b1;
                  end
               end
               default: begin
                  state   <= RUN;
                  pending <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_wave_sel_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wave_sel_sched
//  Purpose  : Self-checking bench for wave_sel_sched: directed scenarios
//             with literal expectations, then randomized traffic, all
//             compared every cycle against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wave_sel_sched;

   localparam int DWELL_W        = 16;
   localparam int DB_CYCLES      = 4;
   localparam int TIMEOUT_CYCLES = 8;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               auto_en = 1'b0;
   logic [1:0]         man_sel = 2'b00;
   logic               btn_next = 1'b0;
   logic               period_wrap = 1'b0;
   logic [DWELL_W-1:0] dwell = '0;
   logic [1:0]         sel;
   logic               pending;
   logic               switch_pulse;
   logic [DWELL_W-1:0] period_cnt;

   int checks   = 0;
   int failures = 0;

   wave_sel_sched #(
      .DWELL_W        (DWELL_W),
      .DB_CYCLES      (DB_CYCLES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .auto_en      (auto_en),
      .man_sel      (man_sel),
      .btn_next     (btn_next),
      .period_wrap  (period_wrap),
      .dwell        (dwell),
      .sel          (sel),
      .pending      (pending),
      .switch_pulse (switch_pulse),
      .period_cnt   (period_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // ---------------------------------------------------------------------
   // Behavioural model: inputs reach the decision logic two edges late,
   // the button must differ from its accepted level DB_CYCLES edges in a
   // row, and requests are resolved by the rules of each mode.
   // ---------------------------------------------------------------------
   bit m_valid = 1'b0;
   int m_sel, m_cnt, m_stall, streak;
   bit m_pend, m_pulse, m_mode, btn_acc;
   bit ah[2];
   int mh[2];
   bit bh[2];

   always @(posedge clk) begin : model
      bit a, b, press, tmo, was_pend;
      int ms, limit;
      if (rst) begin
         m_valid = 1'b1;
         m_sel = 0; m_cnt = 0; m_stall = 0; streak = 0;
         m_pend = 0; m_pulse = 0; m_mode = 0; btn_acc = 0;
         ah = '{0, 0}; mh = '{0, 0}; bh = '{0, 0};
      end else begin
         a = ah[1]; ms = mh[1]; b = bh[1];
         ah[1] = ah[0]; ah[0] = auto_en;
         mh[1] = mh[0]; mh[0] = int'(man_sel);
         bh[1] = bh[0]; bh[0] = btn_next;

         press = 0;
         if (b != btn_acc) begin
            streak++;
            if (streak == DB_CYCLES) begin
               btn_acc = b;
               streak  = 0;
               press   = b;
            end
         end else begin
            streak = 0;
         end

         limit = (dwell == 0) ? 1 : int'(dwell);
         tmo = 0;
`ifdef FORCE_SWITCH_TIMEOUT_EN
         tmo = m_pend && (m_stall + 1 == TIMEOUT_CYCLES);
`endif
         was_pend = m_pend;
         m_pulse  = 0;

         if (a != m_mode) begin
            m_mode = a; m_pend = 0; m_cnt = 0;
         end else if (!a) begin
            m_cnt = 0;
            if (!m_pend) m_pend = (ms != m_sel);
            else if (ms == m_sel) m_pend = 0;
            else if (period_wrap || tmo) begin
               m_sel = ms; m_pend = 0; m_pulse = 1;
            end
         end else if (!m_pend) begin
            if (period_wrap) begin
               if (press || (m_cnt + 1 >= limit)) begin
                  m_sel = (m_sel + 1) % 4; m_cnt = 0; m_pulse = 1;
               end else begin
                  m_cnt++;
               end
            end else if (press) begin
               m_pend = 1;
            end
         end else if (period_wrap || tmo) begin
            m_sel = (m_sel + 1) % 4; m_cnt = 0; m_pend = 0; m_pulse = 1;
         end

         if (m_pend && was_pend) m_stall++;
         else m_stall = 0;
      end
   end

   // Every-cycle comparison against the model, half a cycle after the edge
   always @(negedge clk) begin
      if (m_valid) begin
         check("model_sel",          int'(sel),          m_sel);
         check("model_pending",      int'(pending),      int'(m_pend));
         check("model_switch_pulse", int'(switch_pulse), int'(m_pulse));
         check("model_period_cnt",   int'(period_cnt),   m_cnt);
      end
   end

   int exp_cnt[5]  = '{1, 2, 0, 1, 2};
   int exp_sel5[5] = '{2, 2, 3, 3, 3};
   int exp_sel4[4] = '{0, 1, 2, 3};

   initial begin
      // Reset
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      check("reset_sel", int'(sel), 0);
      check("reset_pending", int'(pending), 0);
      check("reset_pulse", int'(switch_pulse), 0);
      check("reset_cnt", int'(period_cnt), 0);

      // Manual commit on the next wrap
      man_sel = 2'b10;
      tick(3);
      check("man_pending", int'(pending), 1);
      check("man_sel_held", int'(sel), 0);
      period_wrap = 1'b1;
      tick(1);
      period_wrap = 1'b0;
      check("man_commit_sel", int'(sel), 2);
      check("man_commit_pulse", int'(switch_pulse), 1);
      check("man_commit_pending", int'(pending), 0);
      tick(1);
      check("man_pulse_single", int'(switch_pulse), 0);

      // Manual cancel before any wrap
      man_sel = 2'b11;
      tick(3);
      check("cancel_pending_up", int'(pending), 1);
      man_sel = 2'b10;
      tick(3);
      check("cancel_pending_down", int'(pending), 0);
      check("cancel_sel", int'(sel), 2);

      // Auto mode dwell counting
      dwell = 16'd3;
      auto_en = 1'b1;
      tick(4);
      for (int i = 0; i < 5; i++) begin
         period_wrap = 1'b1;
         tick(1);
         period_wrap = 1'b0;
         check("dwell3_cnt", int'(period_cnt), exp_cnt[i]);
         check("dwell3_sel", int'(sel), exp_sel5[i]);
         tick(9);
      end
      dwell = 16'd0;
      for (int i = 0; i < 4; i++) begin
         period_wrap = 1'b1;
         tick(1);
         period_wrap = 1'b0;
         check("dwell0_sel", int'(sel), exp_sel4[i]);
         check("dwell0_cnt", int'(period_cnt), 0);
         tick(9);
      end

      // Button: glitch rejected, held press accepted, commit on wrap
      dwell = 16'd100;
      btn_next = 1'b1;
      tick(2);
      btn_next = 1'b0;
      tick(8);
      check("glitch_no_pending", int'(pending), 0);
      btn_next = 1'b1;
      tick(6);
      check("press_pending", int'(pending), 1);
      btn_next = 1'b0;
      period_wrap = 1'b1;
      tick(1);
      period_wrap = 1'b0;
      check("press_commit_sel", int'(sel), 0);
      check("press_commit_cnt", int'(period_cnt), 0);
      check("press_commit_pending", int'(pending), 0);
      tick(10);

      // Press landing on the dwell-expiry wrap gives a single advance
      dwell = 16'd2;
      period_wrap = 1'b1;
      tick(1);
      period_wrap = 1'b0;
      check("coinc_cnt_pre", int'(period_cnt), 1);
      tick(5);
      btn_next = 1'b1;
      tick(5);
      period_wrap = 1'b1;
      tick(1);
      period_wrap = 1'b0;
      btn_next = 1'b0;
      check("coinc_single_step", int'(sel), 1);
      check("coinc_pending", int'(pending), 0);
      check("coinc_cnt", int'(period_cnt), 0);
      tick(10);

      // Mode switch while an auto request is pending
      man_sel = 2'b01;
      btn_next = 1'b1;
      tick(6);
      check("auto_pend", int'(pending), 1);
      btn_next = 1'b0;
      auto_en = 1'b0;
      tick(3);
      check("modesw_pending", int'(pending), 0);
      check("modesw_cnt", int'(period_cnt), 0);
      check("modesw_sel", int'(sel), 1);
      tick(10);

      // Reset in the middle of a manual request
      man_sel = 2'b10;
      tick(3);
      check("rstpend_pending", int'(pending), 1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      man_sel = 2'b11;
      check("rstpend_sel", int'(sel), 0);
      check("rstpend_pending_clr", int'(pending), 0);

      // Stalled generator: no wraps at all
      tick(3);
      check("stall_pending", int'(pending), 1);
`ifdef FORCE_SWITCH_TIMEOUT_EN
      tick(8);
      check("timeout_sel", int'(sel), 3);
      check("timeout_pulse", int'(switch_pulse), 1);
      check("timeout_pending", int'(pending), 0);
`else
      tick(100);
      check("no_timeout_sel", int'(sel), 0);
      check("no_timeout_pending", int'(pending), 1);
`endif

      // Randomized traffic, checked by the model every cycle
      for (int i = 0; i < 4000; i++) begin
         rst         = ($urandom_range(599) == 0);
         period_wrap = ($urandom_range(5) == 0);
         if ($urandom_range(19) == 0)  man_sel  = 2'($urandom_range(3));
         if ($urandom_range(149) == 0) auto_en  = ~auto_en;
         if ($urandom_range(99) == 0)  dwell    = DWELL_W'($urandom_range(4));
         if ($urandom_range(4) == 0)   btn_next = ~btn_next;
         tick(1);
      end
      rst = 1'b0;
      period_wrap = 1'b0;
      tick(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
